mips_register_file: RTL and testbench
=====================================

Name: mips_register_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sink of the write-back path: its write address comes from the 5-bit destination-register select mux (rt/rd), and its write data comes from the 32-bit result select mux (ALU/memory).
- Provides two combinational read ports that feed the ALU operand path and store data.
- Adds a third read-only debug port for testbench and register-dump inspection.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH = 32.
- SP_INIT, 32'h0000_03FC, reset value of register 29 ($sp).
- GP_INIT, 32'h0000_0000, reset value of register 28 ($gp).

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- reg_write  input  1  write enable from main control.
- write_reg  input  ADDR_WIDTH  destination register index (from the destination-select mux).
- write_data  input  DATA_WIDTH  write-back value (from the result-select mux).
- read_reg1  input  ADDR_WIDTH  rs index.
- read_reg2  input  ADDR_WIDTH  rt index.
- read_data1  output  DATA_WIDTH  contents of register read_reg1.
- read_data2  output  DATA_WIDTH  contents of register read_reg2.
- dbg_reg  input  ADDR_WIDTH  debug read index.
- dbg_data  output  DATA_WIDTH  contents of register dbg_reg.
- write_count  output  16  number of committed writes since reset; saturating.

Behaviour:
- Storage: 32 registers of DATA_WIDTH bits, updated only on the rising edge of clock.
- Reset (reset=1 at the edge):
  - All registers are cleared to 0, except reg 28 = GP_INIT and reg 29 = SP_INIT.
  - write_count is cleared to 0.
  - Reset has priority over a simultaneous reg_write; the write is dropped.
- Reset mid-program: takes effect at the first edge where reset=1, regardless of the reg_write or write_reg state.
- Write, when reset=0 and reg_write=1 at the edge:
  - If write_reg != 0, reg[write_reg] <= write_data and write_count increments.
  - If write_reg == 0, nothing is written, write_count is unchanged and register 0 stays 0.
- Register 0 is hardwired to zero. It reads 0 on every port at all times, including when write_data is nonzero with reg_write=1.
- Reads on read_data1, read_data2 and dbg_data:
  - Purely combinational from the current register contents; zero-cycle latency after the index changes.
  - Read-during-write to the same index returns the OLD value until the edge. The new value is visible immediately after the edge.
  - There is no internal bypass; the single-cycle datapath does not need one.
- All three read ports are independent. The same index on several ports returns the same value.
- reg_write=0 means no state change; X on write_data or write_reg is tolerated.
- write_count saturates at 16'hFFFF and does not wrap.
- Widths: indices are unsigned and no sign or zero extension is applied. Full DATA_WIDTH values are stored verbatim.
- Post-reset output values are combinational functions of state:
  - read_data1, read_data2 and dbg_data = 0 for any index other than 28 and 29.
  - Index 28 reads GP_INIT and index 29 reads SP_INIT.
  - write_count = 0.

Test Plan:
- Reset: hold reset=1 for one edge with reg_write=1, write_reg=5, write_data=32'hFFFF_FFFF → reg5 reads 0, reg29 reads 32'h0000_03FC, reg28 reads 0, write_count=0.
- Write/read: write 32'hDEAD_BEEF to reg 8 and 32'h0000_0001 to reg 31 on consecutive edges → read_reg1=8 gives 32'hDEAD_BEEF, read_reg2=31 gives 1, write_count=2.
- $zero: reg_write=1, write_reg=0, write_data=32'h1234_5678 → all ports read 0 for index 0, write_count unchanged.
- Read-during-write: reg 9 holds 32'h0000_00AA. Drive write_reg=9, write_data=32'h0000_00BB, read_reg1=9 → before the edge read_data1=32'h0000_00AA, after the edge 32'h0000_00BB.
- Write-enable gating and collision:
  - reg_write=0 with write_reg=10, write_data=7 leaves reg 10 unchanged.
  - reset=1 and reg_write=1 on the same edge leaves reg 10 = 0.
- Sweep and saturation:
  - Write reg[i]=i*32'h0101_0101 for i=1..31, then read all indices via dbg_reg → values match and reg0=0.
  - Force 65540 writes → write_count holds at 16'hFFFF.

Source files
------------

// File: rtl/mips_register_file_if.sv
// Register-file port bundle: write-back sink, two operand read ports, a debug read port
// and the committed-write counter.
interface mips_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [ADDR_WIDTH-1:0] dbg_reg;
  logic [DATA_WIDTH-1:0] dbg_data;
  logic [15:0]           write_count;

  modport master (
    output reg_write, write_reg, write_data, read_reg1, read_reg2, dbg_reg,
    input  read_data1, read_data2, dbg_data, write_count
  );

  modport slave (
    input  reg_write, write_reg, write_data, read_reg1, read_reg2, dbg_reg,
    output read_data1, read_data2, dbg_data, write_count
  );
endinterface

// File: rtl/mips_register_file.sv
// 32-entry MIPS general-purpose register file with $zero hardwired, combinational
// read ports (no bypass) and a saturating count of committed writes.
module mips_register_file #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 5,
  parameter logic [31:0] SP_INIT    = 32'h0000_03FC,
  parameter logic [31:0] GP_INIT    = 32'h0000_0000
) (
  input logic                  clock,
  input logic                  reset,
  mips_register_file_if.slave  rf
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [15:0]           write_count_q;
  logic [15:0]           write_count_d;
  logic                  commit;

  function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
    if (idx == 28)      return DATA_WIDTH'(GP_INIT);
    else if (idx == 29) return DATA_WIDTH'(SP_INIT);
    else                return '0;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Writes to $zero are discarded entirely and do not count as commits.
  assign commit = rf.reg_write && (rf.write_reg != '0);

  always_comb begin
    regs_d        = regs_q;
    write_count_d = write_count_q;
    if (commit) begin
      regs_d[rf.write_reg] = rf.write_data;
      write_count_d        = sat_inc(write_count_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= reset_value(i);
      write_count_q <= '0;
    end else begin
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  // Index 0 is masked at the read side so it reads 0 regardless of storage.
  assign rf.read_data1  = (rf.read_reg1 == '0) ? '0 : regs_q[rf.read_reg1];
  assign rf.read_data2  = (rf.read_reg2 == '0) ? '0 : regs_q[rf.read_reg2];
  assign rf.dbg_data    = (rf.dbg_reg   == '0) ? '0 : regs_q[rf.dbg_reg];
  assign rf.write_count = write_count_q;
endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: expectations are queued as stimulus is
// applied and popped against DUT outputs once they are valid.
module tb_mips_register_file;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  string       tag_q [$];
  logic [31:0] exp_q [$];

  mips_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

  mips_register_file dut (
    .clock (clk),
    .reset (rst),
    .rf    (rf_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic check(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_underflow: observed %h required an expectation", observed);
    end else begin
      tag      = tag_q.pop_front();
      expected = exp_q.pop_front();
      checks++;
      assert (observed === expected) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
    end
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
    rf_if.reg_write  = 1'b1;
    rf_if.write_reg  = idx;
    rf_if.write_data = data;
    tick();
    rf_if.reg_write  = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    rst              = 1'b1;
    rf_if.reg_write  = 1'b1;
    rf_if.write_reg  = 5'd5;
    rf_if.write_data = 32'hFFFF_FFFF;
    rf_if.read_reg1  = '0;
    rf_if.read_reg2  = '0;
    rf_if.dbg_reg    = '0;
    tick();

    // Reset with a colliding write
    rst             = 1'b0;
    rf_if.reg_write = 1'b0;
    rf_if.read_reg1 = 5'd5;
    rf_if.read_reg2 = 5'd29;
    rf_if.dbg_reg   = 5'd28;
    expect_val("reset_reg5", 32'h0);
    expect_val("reset_sp", 32'h0000_03FC);
    expect_val("reset_gp", 32'h0);
    expect_val("reset_count", 32'h0);
    settle();
    check(rf_if.read_data1);
    check(rf_if.read_data2);
    check(rf_if.dbg_data);
    check({16'h0, rf_if.write_count});

    // Basic writes
    write_reg(5'd8, 32'hDEAD_BEEF);
    write_reg(5'd31, 32'h0000_0001);
    rf_if.read_reg1 = 5'd8;
    rf_if.read_reg2 = 5'd31;
    expect_val("rd1_reg8", 32'hDEAD_BEEF);
    expect_val("rd2_reg31", 32'h1);
    expect_val("count_two", 32'd2);
    settle();
    check(rf_if.read_data1);
    check(rf_if.read_data2);
    check({16'h0, rf_if.write_count});

    // $zero stays zero
    write_reg(5'd0, 32'h1234_5678);
    rf_if.read_reg1 = 5'd0;
    rf_if.read_reg2 = 5'd0;
    rf_if.dbg_reg   = 5'd0;
    expect_val("zero_rd1", 32'h0);
    expect_val("zero_rd2", 32'h0);
    expect_val("zero_dbg", 32'h0);
    expect_val("zero_count", 32'd2);
    settle();
    check(rf_if.read_data1);
    check(rf_if.read_data2);
    check(rf_if.dbg_data);
    check({16'h0, rf_if.write_count});

    // Read during write returns old value until the edge
    write_reg(5'd9, 32'h0000_00AA);
    rf_if.reg_write  = 1'b1;
    rf_if.write_reg  = 5'd9;
    rf_if.write_data = 32'h0000_00BB;
    rf_if.read_reg1  = 5'd9;
    expect_val("rdw_before", 32'h0000_00AA);
    settle();
    check(rf_if.read_data1);
    tick();
    rf_if.reg_write = 1'b0;
    expect_val("rdw_after", 32'h0000_00BB);
    check(rf_if.read_data1);

    // Write-enable gating, including X on the write bus
    write_reg(5'd10, 32'h5);
    rf_if.write_reg  = 5'd10;
    rf_if.write_data = 32'h7;
    tick();
    rf_if.write_reg  = 'x;
    rf_if.write_data = 'x;
    tick();
    rf_if.dbg_reg   = 5'd10;
    rf_if.read_reg2 = 5'd9;
    expect_val("gated_reg10", 32'h5);
    expect_val("gated_reg9", 32'h0000_00BB);
    expect_val("gated_count", 32'd5);
    settle();
    check(rf_if.dbg_data);
    check(rf_if.read_data2);
    check({16'h0, rf_if.write_count});

    // Mid-run reset beats a simultaneous write
    rst              = 1'b1;
    rf_if.reg_write  = 1'b1;
    rf_if.write_reg  = 5'd10;
    rf_if.write_data = 32'h7;
    tick();
    rst             = 1'b0;
    rf_if.reg_write = 1'b0;
    rf_if.read_reg1 = 5'd8;
    rf_if.read_reg2 = 5'd29;
    expect_val("collide_reg10", 32'h0);
    expect_val("collide_reg8", 32'h0);
    expect_val("collide_sp", 32'h0000_03FC);
    expect_val("collide_count", 32'd0);
    settle();
    check(rf_if.dbg_data);
    check(rf_if.read_data1);
    check(rf_if.read_data2);
    check({16'h0, rf_if.write_count});

    // Full sweep through all three ports
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) begin
      rf_if.read_reg1 = 5'(i);
      rf_if.read_reg2 = 5'(i);
      rf_if.dbg_reg   = 5'(i);
      v = (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101;
      expect_val($sformatf("sweep_rd1_%0d", i), v);
      expect_val($sformatf("sweep_rd2_%0d", i), v);
      expect_val($sformatf("sweep_dbg_%0d", i), v);
      settle();
      check(rf_if.read_data1);
      check(rf_if.read_data2);
      check(rf_if.dbg_data);
    end
    expect_val("sweep_count", 32'd31);
    check({16'h0, rf_if.write_count});

    // Saturation of the write counter
    rf_if.reg_write = 1'b1;
    for (int k = 0; k < 65503; k++) begin
      rf_if.write_reg  = 5'((k % 31) + 1);
      rf_if.write_data = 32'(k);
      tick();
    end
    expect_val("count_fffe", 32'h0000_FFFE);
    check({16'h0, rf_if.write_count});
    rf_if.write_reg = 5'd3;
    tick();
    expect_val("count_ffff", 32'h0000_FFFF);
    check({16'h0, rf_if.write_count});
    for (int k = 0; k < 36; k++) begin
      rf_if.write_reg  = 5'((k % 31) + 1);
      rf_if.write_data = 32'hA5A5_0000 | 32'(k);
      tick();
    end
    rf_if.reg_write = 1'b0;
    rf_if.dbg_reg   = 5'd5;
    expect_val("count_held", 32'h0000_FFFF);
    expect_val("last_write_reg5", 32'hA5A5_0000 | 32'd35);
    settle();
    check({16'h0, rf_if.write_count});
    check(rf_if.dbg_data);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d pending required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
